matmul_acc_drain: RTL and testbench
===================================

MATMUL_ACC_DRAIN -- requirements
Module: matmul_acc_drain

Interface
- REQ-001: Parameter AccWidth, default 20: accumulator width per element, legal range 17..32.
- REQ-002: clk_i  input  1  sole clock, all state on rising edge.
- REQ-003: rst_i  input  1  asynchronous, active-high reset.
- REQ-004: in_valid_i  input  1  upstream product word valid.
- REQ-005: in_ready_o  output  1  block accepts product word.
- REQ-006: in_data_i  input  64  four packed uint16 2x2 products: element 0 = [63:48], 1 = [47:32], 2 = [31:16], 3 = [15:0].
- REQ-007: in_last_i  input  1  final product of the current accumulation group; sampled with in_valid_i.
- REQ-008: out_valid_o  output  1  result beat valid.
- REQ-009: out_ready_i  input  1  downstream accepts result beat.
- REQ-010: out_data_o  output  32  accumulated element, zero-extended from AccWidth.
- REQ-011: out_idx_o  output  2  element index of current beat, 0..3.
- REQ-012: out_last_o  output  1  high on the beat with out_idx_o = 3.
- REQ-013: out_sat_o  output  1  group saturation flag, constant across all four beats of a group.

Function
- REQ-014: The block has two states, ACC and DRAIN; the reset state is ACC.
- REQ-015: In ACC, in_ready_o = 1 and out_valid_o = 0.
- REQ-016: In DRAIN, in_ready_o = 0 and out_valid_o = 1.
- REQ-017: An input handshake occurs when in_valid_i and in_ready_o are both high.
- REQ-018: On the first handshake of a group, each of the four accumulators loads its zero-extended element; previous contents are discarded.
- REQ-019: On each later handshake in the same group, each accumulator adds its element.
- REQ-020: Addition saturates at 2^AccWidth-1 per element and never wraps.
- REQ-021: Any saturation event in a group sets the sat flag; the flag clears on the first handshake of the next group.
- REQ-022: A handshake with in_last_i = 1 moves the state from ACC to DRAIN on the next edge and sets the drain index to 0.
- REQ-023: A single-beat group (first handshake with in_last_i = 1) is legal and drains the loaded values.
- REQ-024: Latency: last input handshake at edge t gives out_valid_o = 1 after edge t, carrying element 0.
- REQ-025: In DRAIN, out_data_o = accumulator[out_idx_o] and out_sat_o = sat flag.
- REQ-026: An output handshake (out_valid_o and out_ready_i high) increments the index.
- REQ-027: An output handshake at index 3 returns the state to ACC and arms the first-handshake flag.
- REQ-028: out_valid_o, out_data_o, out_idx_o, out_last_o and out_sat_o hold stable while out_valid_o = 1 and out_ready_i = 0.
- REQ-029: Inputs are ignored in DRAIN. No input can be accepted in the same cycle as the final output beat; the earliest next input handshake is one cycle later.
- REQ-030: in_data_i and in_last_i are don't-care when in_valid_i = 0.
- REQ-031: Minimum throughput is one group per (N + 4) cycles, where N is the number of input beats in the group.

Reset
- REQ-032: Asserting rst_i forces immediately, regardless of clock: state ACC, accumulators 0, index 0, sat flag 0, first-handshake flag 1.
- REQ-033: Outputs during reset: in_ready_o = 1, out_valid_o = 0, out_data_o = 0, out_idx_o = 0, out_last_o = 0, out_sat_o = 0.
- REQ-034: Reset asserted mid-group or mid-drain discards all partial results; no beat is emitted after release.
- REQ-035: The first handshake after reset release starts a new group.

Verification
- REQ-036: Single beat 0x0001_0002_0003_0004 with last, out_ready_i = 1 -> beats on four consecutive cycles: 1, 2, 3, 4; idx 0..3; out_last_o only on idx 3; sat 0.
- REQ-037: Three beats of 0x00FF_0001_0000_FFFF, last on the third -> 765, 3, 0, 196605; sat 0.
- REQ-038: AccWidth = 17, three beats of 0xFFFF in every element -> every element 131071 and sat 1; next group 0x0000_0000_0000_0001 single beat -> 0, 0, 0, 1 with sat 0.
- REQ-039: Backpressure: out_ready_i low for 5 cycles at idx 1 -> data and idx stable; in_ready_o = 0 throughout the stall; in_valid_i held high is not consumed until after idx 3 completes.
- REQ-040: rst_i pulsed asynchronously between clock edges during DRAIN at idx 2 -> outputs match REQ-033 immediately; after release, a single beat 0x0005_0006_0007_0008 drains as 5, 6, 7, 8.

Source files
------------

// File: rtl/matmul_acc_drain.sv
// Four-lane saturating accumulator for packed 2x2 uint16 products; after the
// last beat of a group it drains the four sums one element per output beat.
module matmul_acc_drain #(
  parameter int unsigned AccWidth = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] in_data_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [1:0]  out_idx_o,
  output logic        out_last_o,
  output logic        out_sat_o
);

  typedef enum logic {
    ACC,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [AccWidth-1:0] acc_q [4];
  logic [AccWidth-1:0] acc_d [4];
  logic [1:0]          idx_q, idx_d;
  logic                sat_q, sat_d;
  logic                first_q, first_d;

  logic [15:0]         elem [4];
  logic [AccWidth:0]   sum  [4];
  logic                in_hs, out_hs;

  always_comb begin
    elem[0] = in_data_i[63:48];
    elem[1] = in_data_i[47:32];
    elem[2] = in_data_i[31:16];
    elem[3] = in_data_i[15:0];

    in_hs  = (state_q == ACC) && in_valid_i;
    out_hs = (state_q == DRAIN) && out_ready_i;

    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    first_d = first_q;
    for (int unsigned i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
      sum[i]   = {1'b0, acc_q[i]} + (AccWidth + 1)'(elem[i]);
    end

    if (in_hs) begin
      // A first beat only loads, so it can never saturate and clears the flag.
      if (first_q) begin
        sat_d = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
          acc_d[i] = AccWidth'(elem[i]);
        end
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (sum[i][AccWidth]) begin
            acc_d[i] = '1;
            sat_d    = 1'b1;
          end else begin
            acc_d[i] = sum[i][AccWidth-1:0];
          end
        end
      end
      first_d = 1'b0;
      if (in_last_i) begin
        state_d = DRAIN;
        idx_d   = '0;
      end
    end

    if (out_hs) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        state_d = ACC;
        first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACC;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      first_q <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      first_q <= first_d;
      for (int unsigned i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  // Outputs are decoded straight from flops and forced to zero outside DRAIN.
  always_comb begin
    in_ready_o  = (state_q == ACC);
    out_valid_o = (state_q == DRAIN);
    out_idx_o   = idx_q;
    out_last_o  = (state_q == DRAIN) && (idx_q == 2'd3);
    out_sat_o   = (state_q == DRAIN) && sat_q;
    out_data_o  = '0;
    if (state_q == DRAIN) begin
      out_data_o[AccWidth-1:0] = acc_q[idx_q];
    end
  end

endmodule

// File: tb/tb_matmul_acc_drain.sv
// Directed bench: default-width and 17-bit instances share one stimulus stream.
module tb_matmul_acc_drain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, out_sat;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic        in_ready17, out_valid17, out_last17, out_sat17;
  logic [31:0] out_data17;
  logic [1:0]  out_idx17;

  int n_cmp = 0;
  int n_err = 0;

  matmul_acc_drain dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_idx_o  (out_idx),
    .out_last_o (out_last),
    .out_sat_o  (out_sat)
  );

  matmul_acc_drain #(.AccWidth(17)) dut17 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready17),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid17),
    .out_ready_i(out_ready),
    .out_data_o (out_data17),
    .out_idx_o  (out_idx17),
    .out_last_o (out_last17),
    .out_sat_o  (out_sat17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][31:0] pk(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("send_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_last  = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  out_data,       32'd0);
    check({tag, "_out_idx"},   32'(out_idx),   32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_out_sat"},   32'(out_sat),   32'd0);
  endtask

  task automatic drain4(input string tag,
                        input logic [3:0][31:0] exp20, input logic sat20,
                        input logic [3:0][31:0] exp17, input logic sat17);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"},    32'(out_valid),   32'd1);
      check({tag, "_in_ready"}, 32'(in_ready),    32'd0);
      check({tag, "_idx"},      32'(out_idx),     32'(i));
      check({tag, "_data"},     out_data,         exp20[i]);
      check({tag, "_last"},     32'(out_last),    32'(i == 3));
      check({tag, "_sat"},      32'(out_sat),     32'(sat20));
      check({tag, "_data17"},   out_data17,       exp17[i]);
      check({tag, "_sat17"},    32'(out_sat17),   32'(sat17));
      tick();
    end
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Single-beat group
    send(64'h0001_0002_0003_0004, 1'b1);
    drain4("single", pk(1, 2, 3, 4), 1'b0, pk(1, 2, 3, 4), 1'b0);

    // Three-beat group; the 17-bit lane 3 saturates (3 * 65535 > 131071)
    send(64'h00FF_0001_0000_FFFF, 1'b0);
    check("mid_group_valid", 32'(out_valid), 32'd0);
    send(64'h00FF_0001_0000_FFFF, 1'b0);
    send(64'h00FF_0001_0000_FFFF, 1'b1);
    drain4("three", pk(765, 3, 0, 196605), 1'b0, pk(765, 3, 0, 131071), 1'b1);

    // All lanes at 0xFFFF for three beats
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain4("satgrp", pk(196605, 196605, 196605, 196605), 1'b0,
           pk(131071, 131071, 131071, 131071), 1'b1);

    // Next group must reload and clear the sat flag
    send(64'h0000_0000_0000_0001, 1'b1);
    drain4("after_sat", pk(0, 0, 0, 1), 1'b0, pk(0, 0, 0, 1), 1'b0);

    // Backpressure at idx 1 with an input held valid throughout
    send(64'h000A_000B_000C_000D, 1'b1);
    out_ready = 1'b1;
    check("bp_idx0_data", out_data, 32'd10);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h0001_0001_0001_0001;
    in_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_stall_valid",    32'(out_valid), 32'd1);
      check("bp_stall_idx",      32'(out_idx),   32'd1);
      check("bp_stall_data",     out_data,       32'd11);
      check("bp_stall_last",     32'(out_last),  32'd0);
      check("bp_stall_in_ready", 32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    check("bp_idx1_data", out_data, 32'd11);
    tick();
    check("bp_idx2_data", out_data, 32'd12);
    tick();
    check("bp_idx3_data",     out_data,       32'd13);
    check("bp_idx3_last",     32'(out_last),  32'd1);
    check("bp_idx3_in_ready", 32'(in_ready),  32'd0);
    tick();
    check("bp_acc_valid",    32'(out_valid), 32'd0);
    check("bp_acc_in_ready", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    drain4("bp_held", pk(1, 1, 1, 1), 1'b0, pk(1, 1, 1, 1), 1'b0);

    // Asynchronous reset mid-drain at idx 2
    send(64'h0010_0020_0030_0040, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("rst_pre_idx",  32'(out_idx), 32'd2);
    check("rst_pre_data", out_data,     32'd48);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_release_valid", 32'(out_valid), 32'd0);
    send(64'h0005_0006_0007_0008, 1'b1);
    drain4("after_rst", pk(5, 6, 7, 8), 1'b0, pk(5, 6, 7, 8), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
